square_gen: RTL and testbench
=============================

// Module: square_gen
// PURPOSE
//  Programmable square-wave source on REFCLK; its square_out drives square_in of the
//  impulse core (upstream stage of the impulse generator). High time, low time,
//  continuous/burst mode are set over the native register bus (REFCLK domain).
//  Glitch-free: no runt high or low phase under any register write or disable.
// PARAMETERS
//  NATIVE_ADDR_WDITH  2   native bus address width (4 registers)
//  NATIVE_DATA_WIDTH  16  native bus data width; also phase/burst counter width
// PORTS
//  REFCLK           in   1    sole clock
//  rst_n            in   1    asynchronous active-low reset
//  NATIVE_EN        in   1    bus access strobe, one cycle per access
//  NATIVE_WR        in   1    1=write, 0=read (qualified by NATIVE_EN)
//  NATIVE_ADDR      in   AW   register address
//  NATIVE_DATA_IN   in   DW   write data
//  NATIVE_DATA_OUT  out  DW   read data, valid while NATIVE_READY=1
//  NATIVE_READY     out  1    access complete, one-cycle pulse
//  square_out       out  1    generated square wave (registered)
//  edge_stb         out  1    one-cycle pulse, cycle square_out rises
//  busy             out  1    1 when FSM not IDLE
//  done             out  1    one-cycle pulse when a burst ends
// BEHAVIOUR
//  Reset: all outputs 0; CTRL=0, HIGH_CYC=1, LOW_CYC=1, BURST_N=0; FSM=IDLE.
//  Registers: 0 CTRL{[2]START w1-pulse, reads 0; [1]MODE 0=cont 1=burst; [0]EN}
//   1 HIGH_CYC, 2 LOW_CYC, 3 BURST_N. Value 0 in HIGH/LOW_CYC treated as 1.
//  Bus: access sampled at edge E with NATIVE_EN=1; write updates register at E;
//   NATIVE_READY=1 in cycle after E with read data; every access gets READY, latency 1.
//   Reads of unused CTRL bits return 0.
//  FSM IDLE/HIGH/LOW; phase counter cnt.
//   IDLE->HIGH: MODE=0 and EN=1; or MODE=1, EN=1, START written, BURST_N!=0
//    (loads remaining=BURST_N). START ignored when busy or BURST_N=0.
//   On every entry to HIGH, shadow HIGH_CYC/LOW_CYC; mid-period writes apply next period.
//   HIGH: square_out=1 exactly hi_sh cycles, then LOW.
//   LOW: square_out=0 exactly lo_sh cycles, then:
//    cont: EN=1 -> HIGH, EN=0 -> IDLE.
//    burst: remaining-1; 0 -> IDLE with done pulse; else HIGH (EN=0 also ends -> IDLE, done).
//  EN cleared mid-HIGH/LOW: current period finishes fully, then IDLE (no runt).
//  Latency: write enabling output at edge E -> square_out=1 and edge_stb=1 from edge E+1.
//  MODE change while busy takes effect only from IDLE.
//  Period = hi_sh+lo_sh cycles; counters never wrap (compare, reset to 0 on phase change).
//  rst_n low any time: immediate return to reset values, square_out=0 asynchronously.
// STRUCTURE
//  Package sq_gen_pkg: register address localparams, CTRL bit indices, FSM state enum.
//  Sub-module sq_gen_regs: native bus decode, register file, START pulse, READY.
//  Top: FSM, phase counter, burst counter, shadow registers, output flops.
// TESTING
//  HIGH=3, LOW=5, cont, EN=1 -> period 8, duty 3/8, edge_stb every 8 cycles, first
//   rise 1 cycle after write edge.
//  Burst: BURST_N=4, HIGH=LOW=2, START -> exactly 4 pulses, done 1 cycle, busy drops.
//  HIGH=0, LOW=0 -> treated 1/1: period 2.
//  Write HIGH=10 mid-HIGH of period HIGH=2 -> current pulse 2 cycles, next 10.
//  EN=0 at 1st cycle of HIGH (HIGH=4, LOW=4) -> full 4-high/4-low then IDLE.
//  START with BURST_N=0, and START while busy -> ignored; READY still pulses.
//  rst_n low mid-HIGH -> square_out=0 immediately, regs at reset values.

Source files
------------

// File: rtl/sq_gen_pkg.sv
// Shared definitions for the square-wave generator: register map, CTRL bit
// positions and the FSM state type.
package sq_gen_pkg;

  localparam int unsigned ADDR_CTRL  = 0;
  localparam int unsigned ADDR_HIGH  = 1;
  localparam int unsigned ADDR_LOW   = 2;
  localparam int unsigned ADDR_BURST = 3;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_START = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/sq_gen_if.sv
// Native register bus between a bus master and the square-wave generator.
interface sq_gen_if #(
  parameter int AW = 2,
  parameter int DW = 16
);
  logic          native_en;
  logic          native_wr;
  logic [AW-1:0] native_addr;
  logic [DW-1:0] native_data_in;
  logic [DW-1:0] native_data_out;
  logic          native_ready;

  modport master (
    output native_en, native_wr, native_addr, native_data_in,
    input  native_data_out, native_ready
  );

  modport slave (
    input  native_en, native_wr, native_addr, native_data_in,
    output native_data_out, native_ready
  );
endinterface

// File: rtl/sq_gen_regs.sv
// Register file for the square-wave generator: bus decode, CTRL/HIGH/LOW/BURST
// storage, one-cycle START pulse and single-cycle READY handshake.
module sq_gen_regs
  import sq_gen_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 16
) (
  input  logic          REFCLK,
  input  logic          rst_n,
  sq_gen_if.slave       bus,
  output logic          ctrl_en,
  output logic          ctrl_mode,
  output logic          start_pulse,
  output logic [DW-1:0] high_cyc,
  output logic [DW-1:0] low_cyc,
  output logic [DW-1:0] burst_n
);

  logic [DW-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (bus.native_addr)
      AW'(ADDR_CTRL): begin
        rd_data[CTRL_EN]   = ctrl_en;
        rd_data[CTRL_MODE] = ctrl_mode;
      end
      AW'(ADDR_HIGH):  rd_data = high_cyc;
      AW'(ADDR_LOW):   rd_data = low_cyc;
      AW'(ADDR_BURST): rd_data = burst_n;
      default:         rd_data = '0;
    endcase
  end

  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en             <= 1'b0;
      ctrl_mode           <= 1'b0;
      start_pulse         <= 1'b0;
      high_cyc            <= DW'(1);
      low_cyc             <= DW'(1);
      burst_n             <= '0;
      bus.native_ready    <= 1'b0;
      bus.native_data_out <= '0;
    end else begin
      start_pulse         <= 1'b0;
      bus.native_ready    <= bus.native_en;
      bus.native_data_out <= '0;
      if (bus.native_en) begin
        bus.native_data_out <= rd_data;
        if (bus.native_wr) begin
          case (bus.native_addr)
            AW'(ADDR_CTRL): begin
              ctrl_en     <= bus.native_data_in[CTRL_EN];
              ctrl_mode   <= bus.native_data_in[CTRL_MODE];
              start_pulse <= bus.native_data_in[CTRL_START];
            end
            AW'(ADDR_HIGH):  high_cyc <= bus.native_data_in;
            AW'(ADDR_LOW):   low_cyc  <= bus.native_data_in;
            AW'(ADDR_BURST): burst_n  <= bus.native_data_in;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/square_gen.sv
// Programmable square-wave source with continuous and burst modes; phase
// lengths are shadowed at every rising edge so register writes never cause runts.
module square_gen
  import sq_gen_pkg::*;
#(
  parameter int NATIVE_ADDR_WDITH = 2,
  parameter int NATIVE_DATA_WIDTH = 16
) (
  input  logic REFCLK,
  input  logic rst_n,
  sq_gen_if.slave bus,
  output logic square_out,
  output logic edge_stb,
  output logic busy,
  output logic done
);

  localparam int DW = NATIVE_DATA_WIDTH;

  logic          ctrl_en, ctrl_mode, start_pulse;
  logic [DW-1:0] high_cyc, low_cyc, burst_n;
  logic [DW-1:0] hi_eff, lo_eff;
  logic [DW-1:0] cnt, hi_sh, lo_sh, remaining;
  logic          mode_sh;
  state_t        state;

  sq_gen_regs #(.AW(NATIVE_ADDR_WDITH), .DW(DW)) u_regs (
    .REFCLK      (REFCLK),
    .rst_n       (rst_n),
    .bus         (bus),
    .ctrl_en     (ctrl_en),
    .ctrl_mode   (ctrl_mode),
    .start_pulse (start_pulse),
    .high_cyc    (high_cyc),
    .low_cyc     (low_cyc),
    .burst_n     (burst_n)
  );

  // A programmed length of 0 behaves as 1 so a phase can never vanish.
  assign hi_eff = (high_cyc == '0) ? DW'(1) : high_cyc;
  assign lo_eff = (low_cyc  == '0) ? DW'(1) : low_cyc;

  always_ff @(posedge REFCLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hi_sh      <= DW'(1);
      lo_sh      <= DW'(1);
      remaining  <= '0;
      mode_sh    <= 1'b0;
      square_out <= 1'b0;
      edge_stb   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      edge_stb <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ctrl_en && (!ctrl_mode || (start_pulse && burst_n != '0))) begin
            state      <= ST_HIGH;
            cnt        <= '0;
            hi_sh      <= hi_eff;
            lo_sh      <= lo_eff;
            mode_sh    <= ctrl_mode;
            remaining  <= burst_n;
            square_out <= 1'b1;
            edge_stb   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt == hi_sh - DW'(1)) begin
            state      <= ST_LOW;
            cnt        <= '0;
            square_out <= 1'b0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        ST_LOW: begin
          if (cnt == lo_sh - DW'(1)) begin
            cnt <= '0;
            // EN and the burst count are only consulted at the end of a full period.
            if (ctrl_en && (!mode_sh || remaining != DW'(1))) begin
              state      <= ST_HIGH;
              hi_sh      <= hi_eff;
              lo_sh      <= lo_eff;
              square_out <= 1'b1;
              edge_stb   <= 1'b1;
              if (mode_sh) remaining <= remaining - DW'(1);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= mode_sh;
            end
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          square_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_gen.sv
// Self-checking bench for square_gen: directed and randomized waveforms compared
// against a period-list reference model built from the register rules.
module tb_square_gen;

  logic REFCLK = 1'b0;
  logic rst_n;
  logic square_out, edge_stb, busy, done;

  always #5 REFCLK = ~REFCLK;

  sq_gen_if #(.AW(2), .DW(16)) bus ();

  square_gen #(.NATIVE_ADDR_WDITH(2), .NATIVE_DATA_WIDTH(16)) dut (
    .REFCLK     (REFCLK),
    .rst_n      (rst_n),
    .bus        (bus),
    .square_out (square_out),
    .edge_stb   (edge_stb),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          w;
    logic [1:0]  addr;
    logic [15:0] data;
  } mid_t;

  mid_t mids[2];
  bit   exp_sq[$];
  bit   exp_stb[$];
  int   exp_len;
  bit   exp_burst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mids();
    for (int i = 0; i < 2; i++) begin
      mids[i].w = 0; mids[i].addr = 2'd0; mids[i].data = 16'd0;
    end
  endtask

  task automatic set_mid(input int i, input int w, input int a, input int d);
    mids[i].w = w; mids[i].addr = 2'(a); mids[i].data = 16'(d);
  endtask

  // Expected waveform as a list of whole periods; a write at offset w affects
  // only periods that start at a later edge.
  task automatic build_model(input int h, input int l, input int n, input bit burst);
    int s, cur_h, cur_l, left, hh, ll;
    bit en;
    bit applied[2];
    s = 1; cur_h = h; cur_l = l; left = n; en = 1'b1;
    applied[0] = 1'b0; applied[1] = 1'b0;
    exp_sq.delete(); exp_stb.delete();
    while (exp_sq.size() < 400) begin
      for (int i = 0; i < 2; i++) begin
        if (!applied[i] && mids[i].w > 0 && mids[i].w < s) begin
          applied[i] = 1'b1;
          case (mids[i].addr)
            2'd0: en = mids[i].data[0];
            2'd1: cur_h = int'(mids[i].data);
            2'd2: cur_l = int'(mids[i].data);
            default: ;
          endcase
        end
      end
      if (!en || (burst && left == 0)) break;
      hh = (cur_h == 0) ? 1 : cur_h;
      ll = (cur_l == 0) ? 1 : cur_l;
      for (int j = 0; j < hh; j++) begin exp_sq.push_back(1'b1); exp_stb.push_back(j == 0); end
      for (int j = 0; j < ll; j++) begin exp_sq.push_back(1'b0); exp_stb.push_back(1'b0); end
      s += hh + ll;
      left--;
    end
    exp_len   = exp_sq.size();
    exp_burst = burst;
  endtask

  task automatic bus_write(input int a, input int d);
    @(negedge REFCLK);
    bus.native_en = 1'b1; bus.native_wr = 1'b1;
    bus.native_addr = 2'(a); bus.native_data_in = 16'(d);
    @(posedge REFCLK);
    #1;
    bus.native_en = 1'b0; bus.native_wr = 1'b0;
  endtask

  task automatic setup_write(input int a, input int d);
    bus_write(a, d);
    @(negedge REFCLK);
    chk("setup_ready", {31'd0, bus.native_ready}, 32'd1);
  endtask

  task automatic bus_read(input int a, input int exp, input string tag);
    @(negedge REFCLK);
    bus.native_en = 1'b1; bus.native_wr = 1'b0; bus.native_addr = 2'(a);
    @(posedge REFCLK);
    #1;
    bus.native_en = 1'b0;
    @(negedge REFCLK);
    chk({tag, "_ready"}, {31'd0, bus.native_ready}, 32'd1);
    chk(tag, {16'd0, bus.native_data_out}, 32'(exp));
  endtask

  // Called right after the enabling write edge E; sample k is the negedge after E+k.
  task automatic run_wave(input string tag);
    int total;
    logic [3:0] ev;
    bit mid_here;
    total = exp_len + 3;
    for (int i = 0; i < 2; i++) if (mids[i].w + 2 > total) total = mids[i].w + 2;
    for (int k = 0; k <= total; k++) begin
      @(negedge REFCLK);
      if (k >= 1 && k <= exp_len)
        ev = {exp_sq[k-1], exp_stb[k-1], 1'b1, 1'b0};
      else if (k == exp_len + 1)
        ev = {3'b000, exp_burst && exp_len > 0};
      else
        ev = 4'b0000;
      chk($sformatf("%s k=%0d {sq,stb,busy,done}", tag, k),
          {28'd0, square_out, edge_stb, busy, done}, {28'd0, ev});
      mid_here = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (mids[i].w > 0 && k == mids[i].w) begin
          mid_here = 1'b1;
          chk($sformatf("%s mid_ready k=%0d", tag, k), {31'd0, bus.native_ready}, 32'd1);
          bus.native_en = 1'b0; bus.native_wr = 1'b0;
        end
      end
      if (k == 0) chk({tag, " start_ready"}, {31'd0, bus.native_ready}, 32'd1);
      if (k == 1 && !mid_here) chk({tag, " ready_idle"}, {31'd0, bus.native_ready}, 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (mids[i].w > 0 && k == mids[i].w - 1) begin
          bus.native_en = 1'b1; bus.native_wr = 1'b1;
          bus.native_addr = mids[i].addr; bus.native_data_in = mids[i].data;
        end
      end
    end
  endtask

  task automatic start_test(input int h, input int l, input int n, input int ctrl,
                            input bit burst, input string tag);
    setup_write(1, h);
    setup_write(2, l);
    setup_write(3, n);
    build_model(h, l, n, burst);
    bus_write(0, ctrl);
    run_wave(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int h, l, n, p, w2;
    bit burst;
    rst_n = 1'b0;
    bus.native_en = 1'b0; bus.native_wr = 1'b0;
    bus.native_addr = 2'd0; bus.native_data_in = 16'd0;
    clear_mids();
    repeat (3) @(negedge REFCLK);
    chk("reset_outputs", {28'd0, square_out, edge_stb, busy, done}, 32'd0);
    chk("reset_ready", {31'd0, bus.native_ready}, 32'd0);
    rst_n = 1'b1;
    bus_read(0, 0, "rst_ctrl");
    bus_read(1, 1, "rst_high");
    bus_read(2, 1, "rst_low");
    bus_read(3, 0, "rst_burst");

    clear_mids(); set_mid(0, 30, 0, 0);
    start_test(3, 5, 0, 1, 1'b0, "cont_3_5");

    clear_mids();
    start_test(2, 2, 4, 7, 1'b1, "burst_4");

    clear_mids(); set_mid(0, 7, 0, 0);
    start_test(0, 0, 0, 1, 1'b0, "zero_len");

    clear_mids(); set_mid(0, 2, 1, 10); set_mid(1, 20, 0, 0);
    start_test(2, 3, 0, 1, 1'b0, "mid_high_write");

    clear_mids(); set_mid(0, 2, 0, 0);
    start_test(4, 4, 0, 1, 1'b0, "en_clear_high");

    clear_mids();
    start_test(3, 3, 0, 7, 1'b1, "start_n0");
    bus_read(0, 3, "ctrl_start_reads0");

    clear_mids(); set_mid(0, 4, 0, 7);
    start_test(1, 2, 3, 7, 1'b1, "start_busy");

    for (int it = 0; it < 8; it++) begin
      h = int'($urandom_range(0, 6));
      l = int'($urandom_range(0, 6));
      burst = 1'($urandom_range(0, 1));
      n = burst ? int'($urandom_range(0, 4)) : 0;
      p = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
      clear_mids();
      if (!burst) set_mid(0, int'($urandom_range(1, 3 * p)), 0, 0);
      else if ($urandom_range(0, 1) == 1) set_mid(0, int'($urandom_range(1, n * p + 4)), 0, 2);
      if ($urandom_range(0, 1) == 1) begin
        w2 = int'($urandom_range(1, 2 * p));
        if (w2 == mids[0].w) w2++;
        set_mid(1, w2, int'($urandom_range(1, 2)), int'($urandom_range(0, 5)));
      end
      start_test(h, l, n, burst ? 7 : 1, burst, $sformatf("rand%0d", it));
    end

    clear_mids();
    setup_write(1, 4);
    setup_write(2, 4);
    bus_write(0, 1);
    repeat (3) @(negedge REFCLK);
    chk("pre_reset_high", {31'd0, square_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {28'd0, square_out, edge_stb, busy, done}, 32'd0);
    @(negedge REFCLK);
    rst_n = 1'b1;
    bus_read(0, 0, "rst2_ctrl");
    bus_read(1, 1, "rst2_high");
    bus_read(2, 1, "rst2_low");
    bus_read(3, 0, "rst2_burst");
    repeat (4) @(negedge REFCLK);
    chk("post_reset_idle", {28'd0, square_out, edge_stb, busy, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
